mem_pipe_ram: RTL
=================

Name: mem_pipe_ram

Overview:
Parametrised single-clock RAM and the successor to the 16x32 register-file memory. Generalises width, depth and read latency, and adds:
- per-byte write enables
- a write acknowledge
- out-of-range address detection
- a defined read/write collision rule

Sits behind the block-level bus agent as the generic storage element for the UVM memory environment.

Parameters:
DATA_W, 32, data width in bits; must be a multiple of 8, range 8..128
ADDR_W, 4, address width in bits
DEPTH, 16, number of implemented words; must satisfy 1 <= DEPTH <= 2**ADDR_W
RD_LAT, 1, read latency in cycles from request to rd_valid; range 1..4

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
en  in  1  block enable; rd_en/wr_en ignored when low
rd_en  in  1  read request, sampled when en=1
wr_en  in  1  write request, sampled when en=1
addr  in  ADDR_W  shared read/write word address
wr_data  in  DATA_W  write data
wr_be  in  DATA_W/8  byte enables; bit i covers wr_data[8i+7:8i]
rd_data  out  DATA_W  read data, qualified by rd_valid
rd_valid  out  1  one-cycle pulse per accepted read
rd_err  out  1  with rd_valid, read address was out of range
wr_ack  out  1  one-cycle pulse per accepted write
wr_err  out  1  with wr_ack, write address was out of range

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - rd_data=0, rd_valid=0, rd_err=0, wr_ack=0, wr_err=0.
  - The read pipeline is flushed.
  - Array contents are not reset; contents are undefined until written.
- Accepted read: en=1 and rd_en=1 at edge t.
  - rd_valid=1 for exactly one cycle after edge t+RD_LAT-1, i.e. visible in cycle t+RD_LAT.
  - rd_data carries the word; rd_err carries the range flag.
- Accepted write: en=1 and wr_en=1 at edge t.
  - Each byte i with wr_be[i]=1 is updated at edge t; other bytes keep their value.
  - wr_ack=1 in the following cycle only.
  - wr_be=0 still produces wr_ack (no-op write).
- Pipeline: fully pipelined; one read per cycle sustained. Back-to-back reads give back-to-back rd_valid pulses in request order.
- Out of range (addr >= DEPTH):
  - Write: array unchanged; wr_ack=1 with wr_err=1.
  - Read: rd_data=0 with rd_valid=1 and rd_err=1.
  - In range: wr_err=0 and rd_err=0.
- Simultaneous rd_en and wr_en:
  - Both operations are performed.
  - Read-first: the read returns the pre-write contents when the addresses match.
- Between valid pulses: rd_data holds its last value. rd_err is 0 whenever rd_valid=0.
- en=0: no new operations. Reads already in the pipeline still complete.
- Reset mid-operation:
  - rst at edge t cancels all in-flight reads; no rd_valid appears for them.
  - Any write sampled at the same edge as rst is dropped: no array update, no ack.
  - rst has priority over all requests.

Optional Feature:
MEM_STATS_EN
- Defined:
  - Adds outputs rd_cnt[15:0] and wr_cnt[15:0], counting accepted reads and writes, including out-of-range ones.
  - Counters saturate at 16'hFFFF.
  - Cleared by rst; update one cycle after acceptance, aligned with rd_valid when RD_LAT=1 and with wr_ack.
  - Adds err_cnt[7:0], saturating at 8'hFF, counting rd_err/wr_err events.
- Not defined: ports and logic are absent, and behaviour is otherwise identical.

Test Plan:
All scenarios use DATA_W=32, ADDR_W=4, DEPTH=12 and RD_LAT=2 unless stated.
- Write then read: write 0xDEADBEEF to addr 3 with wr_be=4'hF, then read addr 3 -> wr_ack pulse next cycle; rd_valid two cycles after the read request with rd_data=0xDEADBEEF and rd_err=0.
- Byte merge: write 0x11223344 (be=F) to addr 5, then write 0xAABBCCDD with be=4'b0101, then read -> rd_data=0x11BB33DD.
- Collision: addr 7 holds 0x1; present rd_en=wr_en=1 at addr 7 with wr_data 0x2 -> rd_data=0x1; a subsequent read returns 0x2.
- Out of range: write to addr 13 -> wr_ack=1 and wr_err=1; read addr 13 -> rd_valid=1, rd_err=1, rd_data=0. Addr 0..11 are unchanged.
- Streaming and reset flush:
  - Reads of addr 0,1,2 on consecutive cycles -> three consecutive rd_valid pulses in order.
  - Repeat, asserting rst one cycle after the last request -> no rd_valid after reset and all outputs 0.
- MEM_STATS_EN: 5 reads, 3 writes (one to addr 14) -> rd_cnt=5, wr_cnt=3, err_cnt=1. After rst all counters read 0.

Source files
------------

// File: rtl/mem_pipe_ram.sv
// -----------------------------------------------------------------------------
// mem_pipe_ram
//   Parametrised single-clock RAM with a configurable read latency, per-byte
//   write enables, write acknowledge, out-of-range detection and a read-first
//   collision rule (a read and a write to the same word in the same cycle
//   returns the pre-write contents).
//
// Parameters
//   DATA_W  data width, multiple of 8 (8..128)
//   ADDR_W  address width
//   DEPTH   implemented words, 1..2**ADDR_W; addr >= DEPTH is out of range
//   RD_LAT  cycles from read request to rd_valid_o (1..4)
//
// Ports
//   clk_i       clock, rising edge
//   rst_i       synchronous active-high reset (flushes the read pipeline)
//   en_i        block enable; rd_en_i / wr_en_i ignored while low
//   rd_en_i     read request
//   wr_en_i     write request
//   addr_i      shared word address
//   wr_data_i   write data
//   wr_be_i     byte enables, bit i covers wr_data_i[8i+7:8i]
//   rd_data_o   read data, qualified by rd_valid_o, holds between pulses
//   rd_valid_o  one pulse per accepted read
//   rd_err_o    with rd_valid_o: read address was out of range
//   wr_ack_o    one pulse per accepted write
//   wr_err_o    with wr_ack_o: write address was out of range
//
// Optional feature (macro MEM_STATS_EN)
//   rd_cnt_o / wr_cnt_o  saturating 16-bit counts of accepted reads / writes
//   err_cnt_o            saturating 8-bit count of out-of-range operations
//
// Handshake: there is no back-pressure. A request is accepted on any rising
// edge where en_i=1 and the request bit is 1 and rst_i=0; every accepted
// request produces exactly one response pulse (rd_valid_o after RD_LAT
// cycles, wr_ack_o after one cycle).
// -----------------------------------------------------------------------------
module mem_pipe_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16,
  parameter int RD_LAT = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic                rd_en_i,
  input  logic                wr_en_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   wr_data_i,
  input  logic [DATA_W/8-1:0] wr_be_i,
  output logic [DATA_W-1:0]   rd_data_o,
  output logic                rd_valid_o,
  output logic                rd_err_o,
  output logic                wr_ack_o,
  output logic                wr_err_o
`ifdef MEM_STATS_EN
  ,
  output logic [15:0]         rd_cnt_o,
  output logic [15:0]         wr_cnt_o,
  output logic [7:0]          err_cnt_o
`endif
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              rd_fire;
  logic              wr_fire;
  logic              in_range;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] rd_word;

  assign rd_fire  = en_i & rd_en_i;
  assign wr_fire  = en_i & wr_en_i;
  assign in_range = ({1'b0, addr_i} < DEPTH_C);
  assign idx      = addr_i[IDX_W-1:0];

  // Array read happens before the write lands (nonblocking update), which
  // gives read-first behaviour on a same-address collision.
  always_comb begin
    rd_word = '0;
    if (in_range) rd_word = mem_q[idx];
  end

  // Storage is intentionally not reset. A write sampled together with rst_i
  // is dropped.
  always_ff @(posedge clk_i) begin
    if (!rst_i && wr_fire && in_range) begin
      for (int b = 0; b < BE_W; b++) begin
        if (wr_be_i[b]) mem_q[idx][8*b +: 8] <= wr_data_i[8*b +: 8];
      end
    end
  end

  // Read pipeline. Stage RD_LAT-1 drives the outputs. Data only advances with
  // a valid token so the last stage holds its value between pulses, while the
  // error flag is forced low whenever the token is absent.
  logic              vld_q  [RD_LAT];
  logic              err_q  [RD_LAT];
  logic [DATA_W-1:0] data_q [RD_LAT];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < RD_LAT; i++) begin
        vld_q[i]  <= 1'b0;
        err_q[i]  <= 1'b0;
        data_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= rd_fire;
      err_q[0] <= rd_fire & ~in_range;
      if (rd_fire) data_q[0] <= rd_word;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        err_q[i] <= err_q[i-1];
        if (vld_q[i-1]) data_q[i] <= data_q[i-1];
      end
    end
  end

  assign rd_data_o  = data_q[RD_LAT-1];
  assign rd_valid_o = vld_q[RD_LAT-1];
  assign rd_err_o   = err_q[RD_LAT-1];

  // Write acknowledge, one cycle after acceptance.
  logic wr_ack_q, wr_ack_d;
  logic wr_err_q, wr_err_d;

  always_comb begin
    wr_ack_d = wr_fire;
    wr_err_d = wr_fire & ~in_range;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ack_q <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      wr_ack_q <= wr_ack_d;
      wr_err_q <= wr_err_d;
    end
  end

  assign wr_ack_o = wr_ack_q;
  assign wr_err_o = wr_err_q;

`ifdef MEM_STATS_EN
  logic [15:0] rd_cnt_q, rd_cnt_d;
  logic [15:0] wr_cnt_q, wr_cnt_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic [1:0]  err_inc;
  logic [8:0]  err_sum;

  // Errors are counted at acceptance, so a read and a write both out of
  // range in the same cycle add two.
  always_comb begin
    rd_cnt_d  = rd_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    err_inc   = {1'b0, rd_fire & ~in_range} + {1'b0, wr_fire & ~in_range};
    err_sum   = {1'b0, err_cnt_q} + {7'd0, err_inc};
    err_cnt_d = err_sum[8] ? 8'hFF : err_sum[7:0];
    if (rd_fire && rd_cnt_q != 16'hFFFF) rd_cnt_d = rd_cnt_q + 16'd1;
    if (wr_fire && wr_cnt_q != 16'hFFFF) wr_cnt_d = wr_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign rd_cnt_o  = rd_cnt_q;
  assign wr_cnt_o  = wr_cnt_q;
  assign err_cnt_o = err_cnt_q;
`endif

endmodule
